// File: rtl/iic_reg_seq.sv
// Register-access sequencer: one host write/read command -> iic_rt byte-op series.
// Optional IIC_SEQ_RETRY_EN: retry the whole transfer after an address NACK.
module iic_reg_seq #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] err,
  output logic       eng_valid,
  input  logic       eng_ready,
  output logic [7:0] eng_write,
  input  logic [7:0] eng_read,
  input  logic       eng_ok,
  output logic       eng_rw,
  output logic [1:0] eng_sp
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WLO, S_WHI, S_EVAL, S_ABORT, S_DONE
  } state_t;

  state_t state, state_n;

  logic          rw_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    wd_q;
  logic [1:0]    step;
  logic          aborting;
  logic [1:0]    err_q;
  logic [CW-1:0] tcnt;

  logic [7:0] op_byte;
  logic       op_rw;
  logic [1:0] op_sp;
  logic       last;
  logic       nack;
  logic       wait_done;
  logic       tmo;
  logic       retry_go;

`ifdef IIC_SEQ_RETRY_EN
  localparam int unsigned RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RCW-1:0] rcnt;

  assign retry_go = aborting && (err_q == 2'b01) && (rcnt != RCW'(MAX_RETRY));
`else
  assign retry_go = 1'b0;
`endif

  always_comb begin
    op_byte = 8'h00;
    op_rw   = 1'b0;
    op_sp   = 2'b00;
    unique case (step)
      2'd0: begin
        op_byte = {dev_q, 1'b0};
        op_sp   = 2'b10;
      end
      2'd1: op_byte = reg_q;
      2'd2: begin
        if (rw_q) begin
          op_byte = {dev_q, 1'b1};
          op_sp   = 2'b10;
        end else begin
          op_byte = wd_q;
          op_sp   = 2'b01;
        end
      end
      default: begin
        op_rw = 1'b1;
        op_sp = 2'b01;
      end
    endcase
  end

  assign last      = rw_q ? (step == 2'd3) : (step == 2'd2);
  assign nack      = !eng_rw && !eng_ok;
  assign wait_done = ((state == S_WLO) && !eng_ready) ||
                     ((state == S_WHI) && eng_ready);
  assign tmo       = ((state == S_WLO) || (state == S_WHI)) &&
                     !wait_done && (tcnt == CW'(TIMEOUT_CYC));

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_n = S_ISSUE;
      S_ISSUE: if (eng_ready) state_n = S_WLO;
      S_ABORT: if (eng_ready) state_n = S_WLO;
      S_WLO: begin
        if (!eng_ready) state_n = S_WHI;
        else if (tmo)   state_n = S_DONE;
      end
      S_WHI: begin
        if (eng_ready) state_n = S_EVAL;
        else if (tmo)  state_n = S_DONE;
      end
      S_EVAL: begin
        if (aborting)
          state_n = retry_go ? S_ISSUE : S_DONE;
        // a NACK on the stop-carrying wdata byte needs no release op
        else if (nack)
          state_n = (step == 2'd2 && !rw_q) ? S_DONE : S_ABORT;
        else
          state_n = last ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wd_q      <= '0;
      step      <= '0;
      aborting  <= 1'b0;
      err_q     <= '0;
      tcnt      <= '0;
      rdata     <= '0;
      err       <= '0;
      eng_valid <= 1'b0;
      eng_write <= '0;
      eng_rw    <= 1'b0;
      eng_sp    <= '0;
`ifdef IIC_SEQ_RETRY_EN
      rcnt      <= '0;
`endif
    end else begin
      eng_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rw_q     <= cmd_rw;
            dev_q    <= cmd_dev;
            reg_q    <= cmd_reg;
            wd_q     <= cmd_wdata;
            step     <= '0;
            aborting <= 1'b0;
            err_q    <= '0;
`ifdef IIC_SEQ_RETRY_EN
            rcnt     <= '0;
`endif
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (eng_ready) begin
            eng_valid <= 1'b1;
            eng_write <= op_byte;
            eng_rw    <= op_rw;
            eng_sp    <= op_sp;
          end
        end
        S_ABORT: begin
          tcnt <= '0;
          if (eng_ready) begin
            eng_valid <= 1'b1;
            eng_write <= 8'h00;
            eng_rw    <= 1'b1;
            eng_sp    <= 2'b01;
            aborting  <= 1'b1;
          end
        end
        S_WLO, S_WHI: begin
          tcnt <= tcnt + CW'(1);
          if (tmo) err <= 2'b11;
        end
        S_EVAL: begin
          if (aborting) begin
            if (retry_go) begin
              step     <= '0;
              aborting <= 1'b0;
              err_q    <= '0;
`ifdef IIC_SEQ_RETRY_EN
              rcnt     <= rcnt + RCW'(1);
`endif
            end else begin
              err <= err_q;
            end
          end else if (nack) begin
            err_q <= (step == 2'd0) ? 2'b01 : 2'b10;
            if (step == 2'd2 && !rw_q) err <= 2'b10;
          end else if (last) begin
            err <= 2'b00;
            if (eng_rw) rdata <= eng_read;
          end else begin
            step <= step + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_reg_seq.sv
// Directed bench for iic_reg_seq with a behavioural iic_rt engine model.
// Expected op lists and status codes are hand-derived per command.
module tb_iic_reg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_wdata = '0;
  logic       done;
  logic [7:0] rdata;
  logic [1:0] err;
  logic       eng_valid;
  logic       eng_ready;
  logic [7:0] eng_write;
  logic [7:0] eng_read;
  logic       eng_ok;
  logic       eng_rw;
  logic [1:0] eng_sp;

  iic_reg_seq #(.TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .done(done), .rdata(rdata), .err(err),
    .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_write(eng_write), .eng_read(eng_read),
    .eng_ok(eng_ok), .eng_rw(eng_rw), .eng_sp(eng_sp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [10:0] ops[$];
  logic [8:0]  nack_byte = 9'h100;
  bit          hang = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  int          cyc = 0;
  int          rdy_cyc = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [10:0] op(input logic [7:0] b, input logic rw,
                                     input logic [1:0] sp);
    return {b, rw, sp};
  endfunction

  // engine: ready low 50 cycles per op; NACK on a write of nack_byte
  initial begin
    logic [10:0] cur;
    eng_ready = 1'b1;
    eng_ok    = 1'b1;
    eng_read  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (eng_valid) begin
        cur = {eng_write, eng_rw, eng_sp};
        ops.push_back(cur);
        eng_ready = 1'b0;
        repeat (50) @(posedge clk);
        if (hang) wait (!hang);
        #1;
        eng_ok    = !(cur[2] == 1'b0 && {1'b0, cur[10:3]} == nack_byte);
        eng_read  = rd_val;
        eng_ready = 1'b1;
        rdy_cyc   = cyc;
      end
    end
  end

  task automatic cmp_ops(input string tag, input logic [10:0] exp[$]);
    check({tag, "_nops"}, ops.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ops.size(); i++)
      check($sformatf("%s_op%0d", tag, i), ops[i], exp[i]);
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd,
                         input bit glitch, output logic [7:0] rd,
                         output logic [1:0] er, output int lat);
    int  n;
    int  acc;
    bit  got;
    ops.delete();
    got = 1'b0;
    rd  = '0;
    er  = '0;
    lat = 0;
    n   = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_rw    = rw;
    cmd_dev   = dev;
    cmd_reg   = rg;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 20) begin
        cmd_rw    = 1'b1;
        cmd_dev   = 7'h11;
        cmd_valid = 1'b1;
      end
      if (glitch && i == 21) cmd_valid = 1'b0;
      if (done) begin
        got = 1'b1;
        rd  = rdata;
        er  = err;
        lat = cyc - acc;
      end
    end
    check("done_seen", got, 1);
  endtask

  logic [10:0] exp[$];
  logic [7:0]  rd;
  logic [1:0]  er;
  int          lat;
  int          n;
  int          dc0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_eng_valid", eng_valid, 0);
    check("rst_eng_write", eng_write, 0);
    check("rst_eng_rw", eng_rw, 0);
    check("rst_eng_sp", eng_sp, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // plain write
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, rd, er, lat);
    exp = '{op(8'hA0, 0, 2'b10), op(8'h10, 0, 2'b00), op(8'hA5, 0, 2'b01)};
    cmp_ops("wr", exp);
    check("wr_err", er, 2'b00);
    check("wr_rdata", rd, 8'h00);
    check("wr_done_lat", cyc - rdy_cyc, 2);
    @(posedge clk); #1;
    check("wr_done_pulse", done, 0);
    check("wr_idle_ready", cmd_ready, 1);

    // register read
    rd_val = 8'h3C;
    run_cmd(1'b1, 7'h50, 8'h22, 8'hFF, 1'b0, rd, er, lat);
    exp = '{op(8'hA0, 0, 2'b10), op(8'h22, 0, 2'b00),
            op(8'hA1, 0, 2'b10), op(8'h00, 1, 2'b01)};
    cmp_ops("rd", exp);
    check("rd_err", er, 2'b00);
    check("rd_rdata", rd, 8'h3C);
    rd_val = 8'h00;

    // address NACK
    nack_byte = 9'h0A0;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, rd, er, lat);
`ifdef IIC_SEQ_RETRY_EN
    exp = '{op(8'hA0, 0, 2'b10), op(8'h00, 1, 2'b01),
            op(8'hA0, 0, 2'b10), op(8'h00, 1, 2'b01),
            op(8'hA0, 0, 2'b10), op(8'h00, 1, 2'b01)};
`else
    exp = '{op(8'hA0, 0, 2'b10), op(8'h00, 1, 2'b01)};
`endif
    cmp_ops("anack", exp);
    check("anack_err", er, 2'b01);
    check("anack_rdata_held", rd, 8'h3C);

    // register byte NACK
    nack_byte = 9'h010;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, rd, er, lat);
    exp = '{op(8'hA0, 0, 2'b10), op(8'h10, 0, 2'b00), op(8'h00, 1, 2'b01)};
    cmp_ops("rnack", exp);
    check("rnack_err", er, 2'b10);

    // data byte NACK: stop already sent, no release op
    nack_byte = 9'h0A5;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, rd, er, lat);
    exp = '{op(8'hA0, 0, 2'b10), op(8'h10, 0, 2'b00), op(8'hA5, 0, 2'b01)};
    cmp_ops("dnack", exp);
    check("dnack_err", er, 2'b10);
    nack_byte = 9'h100;

    // hung engine
    hang = 1'b1;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, rd, er, lat);
    check("to_err", er, 2'b11);
    check("to_lat", (lat >= 995 && lat <= 1010), 1);
    repeat (100) @(posedge clk);
    #1;
    check("to_no_more_ops", ops.size(), 1);
    hang = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // reset in the middle of step 1
    rd_val = 8'h5A;
    ops.delete();
    cmd_rw    = 1'b1;
    cmd_dev   = 7'h50;
    cmd_reg   = 8'h22;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (ops.size() < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_step1", ops.size(), 2);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_eng_valid", eng_valid, 0);
    check("mid_eng_write", eng_write, 8'h00);
    check("mid_err", err, 2'b00);
    check("mid_rdata", rdata, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (!eng_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_eng_back", eng_ready, 1);

    // fresh command, cmd_valid pulsed while busy must be ignored
    dc0 = done_cnt;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1, rd, er, lat);
    exp = '{op(8'hA0, 0, 2'b10), op(8'h10, 0, 2'b00), op(8'hA5, 0, 2'b01)};
    cmp_ops("post", exp);
    check("post_err", er, 2'b00);
    repeat (200) @(posedge clk);
    #1;
    check("post_one_done", done_cnt - dc0, 1);
    check("post_no_extra_ops", ops.size(), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
